// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, op/cond codes,
// mux select codes, ALU codes and the registered control-word layout.
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [2:0] COND_EQ = 3'b000;
    localparam logic [2:0] COND_NE = 3'b001;
    localparam logic [2:0] COND_CS = 3'b010;
    localparam logic [2:0] COND_CC = 3'b011;
    localparam logic [2:0] COND_MI = 3'b100;
    localparam logic [2:0] COND_PL = 3'b101;
    localparam logic [2:0] COND_GE = 3'b110;
    localparam logic [2:0] COND_AL = 3'b111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // Control word held in flops; the *_c enables are still gated by cond_ex.
    typedef struct packed {
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] result_src;
        logic       ir_write;
        logic       pc_write_u;
        logic       pc_write_c;
        logic       reg_write_c;
        logic       mem_write_c;
    } ctrl_t;

    // Returns {no_write, alu_control} for a data-processing cmd.
    function automatic logic [3:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: alu_decode = {1'b0, ALU_ADD};
            CMD_SUB: alu_decode = {1'b0, ALU_SUB};
            CMD_AND: alu_decode = {1'b0, ALU_AND};
            CMD_ORR: alu_decode = {1'b0, ALU_ORR};
            CMD_EOR: alu_decode = {1'b0, ALU_EOR};
            CMD_CMP: alu_decode = {1'b1, ALU_SUB};
            default: alu_decode = {1'b1, ALU_ADD};
        endcase
    endfunction

    // Control word of the FETCH state.
    function automatic ctrl_t fetch_ctrl();
        ctrl_t c;
        c = '0;
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_control = ALU_ADD;
        c.result_src  = RES_ALU;
        c.ir_write    = 1'b1;
        c.pc_write_u  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_cond_unit.sv
// Condition unit: stored NZCV flags, cond_ex evaluation and flag-write gating.
module cond_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_req,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic [3:0] flags_q, flags_d;
    logic n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign flags = flags_q;

    // Condition check against the stored (not incoming) flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_GE: cond_ex = (n_f == v_f);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flags load only when the executing instruction requests it and passes.
    always_comb begin
        flags_d = flags_q;
        if (flag_req && cond_ex) flags_d = alu_flags;
    end

    // Flags register.
    always_ff @(posedge clk) begin
        if (reset) flags_q <= FLAGS_RST;
        else       flags_q <= flags_d;
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle controller: Moore FSM sequencing, ALU decode, and gating of
// write enables by the condition unit. Control word is registered from the
// next-state decode; reset and cond_ex act combinationally on the outputs.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int         STATE_W   = 4,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [2:0]         Cond,
    input  logic [3:0]         ALUFlags,
    output logic [2:0]         RegSrc,
    output logic               AdrSrc,
    output logic               RegWrite,
    output logic [1:0]         ImmSrc,
    output logic               AluSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic               MemWrite,
    output logic               PCWrite,
    output logic [1:0]         ResultSrc,
    output logic               IRWrite,
    output logic [STATE_W-1:0] state_dbg,
    output logic [3:0]         flags_dbg
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d, ctrl_o;
    logic [3:0] dec;
    logic       no_write;
    logic       is_cmp;
    logic       flag_req;
    logic       cond_ex;

    assign dec      = alu_decode(Funct[4:1]);
    assign no_write = dec[3];
    assign is_cmp   = (Funct[4:1] == CMD_CMP);
    assign flag_req = ((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) && (Funct[0] || is_cmp);

    cond_unit #(.FLAGS_RST(FLAGS_RST)) u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .flag_req  (flag_req),
        .cond_ex   (cond_ex),
        .flags     (flags_dbg)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control word for the state being entered.
    always_comb begin
        ctrl_d = '0;
        ctrl_d.alu_control = ALU_ADD;
        case (state_d)
            S_FETCH:  ctrl_d = fetch_ctrl();
            S_DECODE: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_src_b  = SRCB_FOUR;
                ctrl_d.result_src = RES_ALU;
            end
            S_MEMADR: ctrl_d.alu_src_b = SRCB_IMM;
            S_MEMREAD: begin
                ctrl_d.adr_src    = 1'b1;
                ctrl_d.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl_d.result_src  = RES_RDATA;
                ctrl_d.reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_d.adr_src     = 1'b1;
                ctrl_d.result_src  = RES_ALUOUT;
                ctrl_d.mem_write_c = 1'b1;
            end
            S_EXECUTER: ctrl_d.alu_control = dec[2:0];
            S_EXECUTEI: begin
                ctrl_d.alu_src_b   = SRCB_IMM;
                ctrl_d.alu_control = dec[2:0];
            end
            S_ALUWB: begin
                ctrl_d.result_src  = RES_ALUOUT;
                ctrl_d.reg_write_c = ~no_write;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_b  = SRCB_IMM;
                ctrl_d.result_src = RES_ALU;
                ctrl_d.pc_write_c = 1'b1;
            end
            default: ctrl_d = fetch_ctrl();
        endcase
    end

    // FSM state and registered control word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= fetch_ctrl();
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Output stage: reset shows FETCH selects, write enables gated by cond_ex and reset.
    always_comb begin
        ctrl_o     = reset ? fetch_ctrl() : ctrl_q;
        AdrSrc     = ctrl_o.adr_src;
        AluSrcA    = ctrl_o.alu_src_a;
        ALUSrcB    = ctrl_o.alu_src_b;
        ALUControl = ctrl_o.alu_control;
        ResultSrc  = ctrl_o.result_src;
        IRWrite    = ~reset & ctrl_o.ir_write;
        PCWrite    = ~reset & (ctrl_o.pc_write_u | (ctrl_o.pc_write_c & cond_ex));
        RegWrite   = ~reset & ctrl_o.reg_write_c & cond_ex;
        MemWrite   = ~reset & ctrl_o.mem_write_c & cond_ex;
        ImmSrc     = Op;
        RegSrc     = {1'b0, Op == OP_MEM, Op == OP_BR};
    end

    assign state_dbg = STATE_W'(state_q);

endmodule
